// File: rtl/rv_pkg.sv
// Shared integer-register-file types: data/address widths and the queued write entry.
// No logic; latency and backpressure belong to the modules that use these types.
package rv_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// Circular write-back buffer with 2-push/1-pop per edge; entries exposed oldest-first for matching.
// One-edge latency from push to head; the caller must never push past DEPTH (no internal backpressure).
module wb_queue
    import rv_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_vld,
    input  wb_entry_t        push0_dat,
    input  logic             push1_vld,
    input  wb_entry_t        push1_dat,
    input  logic             pop,
    output logic [CW-1:0]    count_o,
    output wb_entry_t        head_dat,
    output wb_entry_t        age_dat [DEPTH],
    output logic [DEPTH-1:0] age_vld
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t        ent_q [DEPTH];
    wb_entry_t        ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_en;

    assign pop_en = pop && (count_q != '0);

    // push1 always lands directly behind push0 so acceptance order is preserved
    always_comb begin
        ent_d    = ent_q;
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        if (pop_en) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (push0_vld) begin
            ent_d[wr_ptr_q] = push0_dat;
            vld_d[wr_ptr_q] = 1'b1;
        end
        if (push1_vld) begin
            ent_d[wr_ptr_q + PW'(1)] = push1_dat;
            vld_d[wr_ptr_q + PW'(1)] = 1'b1;
        end
        wr_ptr_d = wr_ptr_q + PW'(push0_vld) + PW'(push1_vld);
        count_d  = count_q + CW'(push0_vld) + CW'(push1_vld) - CW'(pop_en);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_dat[i] = ent_q[rd_ptr_q + PW'(i)];
            age_vld[i] = vld_q[rd_ptr_q + PW'(i)];
        end
    end

    assign head_dat = ent_q[rd_ptr_q];
    assign count_o  = count_q;
endmodule

// File: rtl/regfile_wb_queue.sv
// Queues ALU/load results and retires one per edge to the register-file write port; pend/fwd CAM for decode.
// Accept-to-wb_en latency one edge; readies depend only on registered occupancy (ALU needs 1 slot, load 2).
module regfile_wb_queue
    import rv_pkg::wb_entry_t;
#(
    parameter int XLEN  = rv_pkg::XLEN,
    parameter int AW    = rv_pkg::REG_AW,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [XLEN-1:0] wb_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            pend1,
    output logic            pend2,
    output logic [XLEN-1:0] fwd1,
    output logic [XLEN-1:0] fwd2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic             alu_push, ld_push, pop;
    logic             push0_vld, push1_vld;
    wb_entry_t        alu_ent, ld_ent, push0_dat, head;
    wb_entry_t        age_dat [DEPTH];
    logic [DEPTH-1:0] age_vld;

    logic             wb_en_q, wb_en_d;
    logic [AW-1:0]    wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]  wb_data_q, wb_data_d;

    logic [AW-1:0]    rs_sel [2];
    logic [1:0]       pend_v;
    logic [XLEN-1:0]  fwd_v [2];

    assign alu_ready = (count <= CW'(DEPTH - 1));
    assign ld_ready  = (count <= CW'(DEPTH - 2));

    // x0 writes are consumed by the handshake but never occupy a slot
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign ld_push  = ld_valid && ld_ready && (ld_rd != '0);

    assign alu_ent   = '{rd: alu_rd, data: alu_data};
    assign ld_ent    = '{rd: ld_rd, data: ld_data};
    assign push0_vld = alu_push || ld_push;
    assign push0_dat = alu_push ? alu_ent : ld_ent;
    assign push1_vld = alu_push && ld_push;
    assign pop       = (count != '0);

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push0_vld (push0_vld),
        .push0_dat (push0_dat),
        .push1_vld (push1_vld),
        .push1_dat (ld_ent),
        .pop       (pop),
        .count_o   (count),
        .head_dat  (head),
        .age_dat   (age_dat),
        .age_vld   (age_vld)
    );

    always_comb begin
        wb_en_d   = pop;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (pop) begin
            wb_addr_d = head.rd;
            wb_data_d = head.data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign rs_sel[0] = rs1;
    assign rs_sel[1] = rs2;

    // Scan oldest to youngest so the youngest match overrides; the wb stage is older than every queue entry
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            pend_v[p] = 1'b0;
            fwd_v[p]  = '0;
            if (wb_en_q && (wb_addr_q == rs_sel[p])) begin
                pend_v[p] = 1'b1;
                fwd_v[p]  = wb_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (age_vld[i] && (age_dat[i].rd == rs_sel[p])) begin
                    pend_v[p] = 1'b1;
                    fwd_v[p]  = age_dat[i].data;
                end
            end
            if (rs_sel[p] == '0) begin
                pend_v[p] = 1'b0;
                fwd_v[p]  = '0;
            end
        end
    end

    assign pend1   = pend_v[0];
    assign pend2   = pend_v[1];
    assign fwd1    = fwd_v[0];
    assign fwd2    = fwd_v[1];
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = wb_data_q;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: an in-order queue model checked every negedge,
// plus literal expectations for each scenario and the retired-write order.
module tb_regfile_wb_queue;
    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            alu_valid = 1'b0, ld_valid = 1'b0;
    logic            alu_ready, ld_ready;
    logic [AW-1:0]   alu_rd = '0, ld_rd = '0, rs1 = '0, rs2 = '0;
    logic [XLEN-1:0] alu_data = '0, ld_data = '0;
    logic            wb_en, pend1, pend2;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data, fwd1, fwd2;

    regfile_wb_queue #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs1(rs1), .rs2(rs2), .pend1(pend1), .pend2(pend2), .fwd1(fwd1), .fwd2(fwd2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: ordered list of pending writes plus the last retired write
    typedef struct packed { logic [4:0] rd; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    logic        m_en = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          msz;
    bit          a_acc, l_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            msz   = mq.size();
            a_acc = alu_valid && (msz <= DEPTH - 1);
            l_acc = ld_valid && (msz <= DEPTH - 2);
            if (msz > 0) begin
                m_en   = 1'b1;
                m_addr = mq[0].rd;
                m_data = mq[0].data;
                void'(mq.pop_front());
            end else begin
                m_en = 1'b0;
            end
            if (a_acc && alu_rd != 0) mq.push_back('{alu_rd, alu_data});
            if (l_acc && ld_rd != 0)  mq.push_back('{ld_rd, ld_data});
        end
    end

    function automatic void m_lookup(input logic [4:0] rs, output logic p, output logic [31:0] f);
        p = 1'b0;
        f = '0;
        if (rs == 0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == rs) begin
                p = 1'b1;
                f = mq[i].data;
                return;
            end
        end
        if (m_en && m_addr == rs) begin
            p = 1'b1;
            f = m_data;
        end
    endfunction

    bit          mon_on = 1'b0;
    logic [31:0] rf [32];
    logic [4:0]  log_rd[$];
    logic [31:0] log_dat[$];
    logic        ep1, ep2;
    logic [31:0] ef1, ef2;

    initial for (int i = 0; i < 32; i++) rf[i] = '0;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("alu_ready", 32'(alu_ready), 32'(mq.size() <= DEPTH - 1));
            chk("ld_ready", 32'(ld_ready), 32'(mq.size() <= DEPTH - 2));
            chk("wb_en", 32'(wb_en), 32'(m_en));
            chk("wb_addr", 32'(wb_addr), 32'(m_addr));
            chk("wb_data", wb_data, m_data);
            m_lookup(rs1, ep1, ef1);
            m_lookup(rs2, ep2, ef2);
            chk("pend1", 32'(pend1), 32'(ep1));
            chk("pend2", 32'(pend2), 32'(ep2));
            chk("fwd1", fwd1, ef1);
            chk("fwd2", fwd2, ef2);
        end
        if (wb_en === 1'b1) begin
            rf[wb_addr] = wb_data;
            log_rd.push_back(wb_addr);
            log_dat.push_back(wb_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_rd.delete();
        log_dat.delete();
    endtask

    task automatic chk_log(input int idx, input logic [4:0] rd, input logic [31:0] d);
        if (idx < log_rd.size()) begin
            chk($sformatf("retire%0d_rd", idx), 32'(log_rd[idx]), 32'(rd));
            chk($sformatf("retire%0d_data", idx), log_dat[idx], d);
        end else begin
            chk($sformatf("retire%0d_present", idx), 32'(log_rd.size()), 32'(idx + 1));
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid  = lv; ld_rd  = lr; ld_data  = ld;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mon_on = 1'b1;
        rs1 = 5;
        @(negedge clk);
        chk("t1_wb_en", 32'(wb_en), 0);
        chk("t1_wb_addr", 32'(wb_addr), 0);
        chk("t1_wb_data", wb_data, 0);
        chk("t1_alu_ready", 32'(alu_ready), 1);
        chk("t1_ld_ready", 32'(ld_ready), 1);
        chk("t1_pend1", 32'(pend1), 0);

        // single ALU write, forwarded then retired
        clear_log();
        step();
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_pend1", 32'(pend1), 1);
        chk("t2_fwd1", fwd1, 32'hDEADBEEF);
        chk("t2_wb_en_early", 32'(wb_en), 0);
        step();
        @(negedge clk);
        chk("t2_wb_en", 32'(wb_en), 1);
        chk("t2_wb_addr", 32'(wb_addr), 5);
        chk("t2_wb_data", wb_data, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("t2_wb_en_after", 32'(wb_en), 0);
        chk("t2_pend1_after", 32'(pend1), 0);
        chk("t2_fwd1_after", fwd1, 0);

        // ALU and load in one cycle: ALU retires first, back to back
        clear_log();
        step();
        drive(1, 1, 32'h11, 1, 2, 32'h22);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_wb_en_early", 32'(wb_en), 0);
        step();
        @(negedge clk);
        chk("t3_first_addr", 32'(wb_addr), 1);
        chk("t3_first_data", wb_data, 32'h11);
        step();
        @(negedge clk);
        chk("t3_second_en", 32'(wb_en), 1);
        chk("t3_second_addr", 32'(wb_addr), 2);
        chk("t3_second_data", wb_data, 32'h22);
        step();
        @(negedge clk);
        chk("t3_idle", 32'(wb_en), 0);
        chk("t3_log_len", 32'(log_rd.size()), 2);

        // x0 write is accepted but dropped
        clear_log();
        step();
        rs1 = 0;
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0);
        @(negedge clk);
        chk("t4_alu_ready", 32'(alu_ready), 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t4_wb_en", 32'(wb_en), 0);
        chk("t4_pend1", 32'(pend1), 0);
        chk("t4_ld_ready", 32'(ld_ready), 1);
        step();
        @(negedge clk);
        chk("t4_wb_en_later", 32'(wb_en), 0);
        chk("t4_log_len", 32'(log_rd.size()), 0);

        // fill with dual pushes while retiring every edge
        clear_log();
        step();
        rs1 = 9;
        rs2 = 13;
        drive(1, 8, 32'h80, 1, 9, 32'h90);
        step();
        drive(1, 10, 32'hA0, 1, 11, 32'hB0);
        step();
        drive(1, 12, 32'hC0, 1, 13, 32'hD0);
        @(negedge clk);
        chk("t5_ld_ready_cnt3", 32'(ld_ready), 0);
        chk("t5_alu_ready_cnt3", 32'(alu_ready), 1);
        chk("t5_pend2_not_taken", 32'(pend2), 0);
        step();
        drive(1, 14, 32'hE0, 1, 13, 32'hD0);
        @(negedge clk);
        chk("t5_ld_ready_held", 32'(ld_ready), 0);
        step();
        drive(0, 0, 0, 1, 13, 32'hD0);
        @(negedge clk);
        chk("t5_ld_ready_still", 32'(ld_ready), 0);
        step();
        @(negedge clk);
        chk("t5_ld_ready_freed", 32'(ld_ready), 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        repeat (8) step();
        chk("t5_log_len", 32'(log_rd.size()), 7);
        chk_log(0, 8, 32'h80);
        chk_log(1, 9, 32'h90);
        chk_log(2, 10, 32'hA0);
        chk_log(3, 11, 32'hB0);
        chk_log(4, 12, 32'hC0);
        chk_log(5, 14, 32'hE0);
        chk_log(6, 13, 32'hD0);

        // two writes to x7: youngest forwards, oldest retires first
        clear_log();
        step();
        rs1 = 7;
        rs2 = 7;
        drive(1, 7, 32'hA5A50007, 1, 7, 32'h5A5A0007);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t6_pend1", 32'(pend1), 1);
        chk("t6_fwd1_young", fwd1, 32'h5A5A0007);
        step();
        @(negedge clk);
        chk("t6_retire_a", wb_data, 32'hA5A50007);
        chk("t6_fwd2_young", fwd2, 32'h5A5A0007);
        step();
        @(negedge clk);
        chk("t6_retire_b", wb_data, 32'h5A5A0007);
        chk("t6_fwd1_wb", fwd1, 32'h5A5A0007);
        step();
        @(negedge clk);
        chk("t6_pend1_done", 32'(pend1), 0);
        chk("t6_x7", rf[7], 32'h5A5A0007);
        chk_log(0, 7, 32'hA5A50007);
        chk_log(1, 7, 32'h5A5A0007);

        // async reset with three entries queued discards them
        clear_log();
        step();
        rs1 = 3;
        rs2 = 4;
        drive(1, 3, 32'h33, 1, 4, 32'h44);
        step();
        drive(1, 5, 32'h55, 1, 6, 32'h66);
        step();
        drive(0, 0, 0, 0, 0, 0);
        chk("t7_wb_en_before", 32'(wb_en), 1);
        #2 reset = 1'b0;
        #1;
        chk("t7_wb_en_async", 32'(wb_en), 0);
        chk("t7_wb_addr_async", 32'(wb_addr), 0);
        chk("t7_pend2_async", 32'(pend2), 0);
        repeat (2) step();
        reset = 1'b1;
        rs1 = 4;
        rs2 = 6;
        repeat (5) step();
        @(negedge clk);
        chk("t7_pend1", 32'(pend1), 0);
        chk("t7_pend2", 32'(pend2), 0);
        chk("t7_no_writes", 32'(log_rd.size()), 0);

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
